// File: rtl/div_sequential.sv
// div_sequential: restoring shift-subtract unsigned divider, one quotient bit per clock.
module div_sequential #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_nxt;
  logic [W-1:0] q, d, q_nxt;
  logic [W:0] r, rs, trial, r_nxt;
  logic [CW-1:0] cnt;
  logic zpend, accept, last;
  // zpend marks an accepted divide-by-zero whose result is published on the following edge
  always_comb begin
    accept = state == IDLE && start && !zpend;
    last = state == CALC && cnt == CW'(1);
    state_nxt = accept && divisor != '0 ? CALC : last ? IDLE : state;
    rs = {r[W-1:0], q[W-1]};
    trial = rs - {1'b0, d};
    r_nxt = trial[W] ? rs : trial;
    q_nxt = {q[W-2:0], ~trial[W]};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= '0;
      r <= '0;
      d <= '0;
      cnt <= '0;
      zpend <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= state_nxt == CALC || zpend;
      zpend <= accept && divisor == '0;
      if (zpend) begin
        quotient <= '1;
        remainder <= q;
        div_by_zero <= 1'b1;
        done <= 1'b1;
      end
      if (accept) begin
        q <= dividend;
        r <= '0;
        d <= divisor;
        cnt <= divisor != '0 ? CW'(W) : '0;
      end else if (state == CALC) begin
        q <= q_nxt;
        r <= r_nxt;
        cnt <= cnt - 1'b1;
        if (last) begin
          quotient <= q_nxt;
          remainder <= r_nxt[W-1:0];
          div_by_zero <= 1'b0;
          done <= 1'b1;
        end
      end
    end
endmodule
